vram_arbiter: RTL

// Arbitrates one single-port synchronous screen RAM between the VGA scan-out fetcher and the CPU data port.

---
 rtl/vram_arbiter.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port screen RAM between VGA scan-out
// and the CPU, with a hardware clear sequencer and a posted write buffer.
module vram_arbiter #(
    parameter int ADDR_W         = 13,
    parameter int DATA_W         = 16,
    parameter int STARVE_LIMIT   = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_valid,
    output logic [DATA_W-1:0] vga_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_RUN,
        ST_FLUSH
    } state_t;

    typedef enum logic [1:0] {
        SL_NONE,
        SL_VGA,
        SL_DRAIN,
        SL_CRD
    } slot_t;

    localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] CLR_LAST = '1;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] clr_cnt;
    logic [SW-1:0]     starve_cnt;

    logic              buf_full;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;

    logic              vga_from_ram;

    slot_t slot;
    logic  cpu_rd_req;
    logic  cpu_side;
    logic  boost;
    logic  drain;
    logic  cpu_won;
    logic  wr_acc;
    logic  buf_full_nxt;

    logic              vga_gnt_c;
    logic              cpu_gnt_c;
    logic              en_c;
    logic              we_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] wdata_c;

    // Slot arbitration: boosted CPU side, then VGA, then drain, then CPU read.
    always_comb begin
        cpu_rd_req = (state == ST_RUN) && cpu_req && !cpu_we;
        cpu_side   = buf_full || cpu_rd_req;
        boost      = cpu_side && (starve_cnt == STARVE_MAX);
        slot       = SL_NONE;
        if (state != ST_CLEAR) begin
            if (boost) begin
                slot = buf_full ? SL_DRAIN : SL_CRD;
            end else if (vga_req) begin
                slot = SL_VGA;
            end else if (buf_full) begin
                slot = SL_DRAIN;
            end else if (cpu_rd_req) begin
                slot = SL_CRD;
            end
        end
        drain        = (slot == SL_DRAIN);
        cpu_won      = drain || (slot == SL_CRD);
        wr_acc       = (state == ST_RUN) && cpu_req && cpu_we
                       && (!buf_full || drain);
        buf_full_nxt = wr_acc || (buf_full && !drain);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a full buffer is flushed before the clear begins.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_CLEAR: begin
                if (clr_cnt == CLR_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clear_start) begin
                    state_nxt = buf_full_nxt ? ST_FLUSH : ST_CLEAR;
                end
            end
            ST_FLUSH: begin
                if (drain) begin
                    state_nxt = ST_CLEAR;
                end
            end
            default: state_nxt = RST_STATE;
        endcase
    end

    // Outputs: grants and the RAM command for the winning slot.
    always_comb begin
        vga_gnt_c = 1'b0;
        cpu_gnt_c = 1'b0;
        en_c      = 1'b0;
        we_c      = 1'b0;
        addr_c    = '0;
        wdata_c   = '0;
        if (state == ST_CLEAR) begin
            vga_gnt_c = vga_req;
            en_c      = 1'b1;
            we_c      = 1'b1;
            addr_c    = clr_cnt;
        end else begin
            vga_gnt_c = (slot == SL_VGA);
            cpu_gnt_c = wr_acc || (slot == SL_CRD);
            unique case (slot)
                SL_VGA: begin
                    en_c   = 1'b1;
                    addr_c = vga_addr;
                end
                SL_DRAIN: begin
                    en_c    = 1'b1;
                    we_c    = 1'b1;
                    addr_c  = buf_addr;
                    wdata_c = buf_data;
                end
                SL_CRD: begin
                    en_c   = 1'b1;
                    addr_c = cpu_addr;
                end
                default: begin
                end
            endcase
        end
    end

    // While reset is held every command and grant is forced low.
    assign vga_gnt    = reset & vga_gnt_c;
    assign cpu_gnt    = reset & cpu_gnt_c;
    assign ram_en     = reset & en_c;
    assign ram_we     = reset & we_c;
    assign ram_addr   = reset ? addr_c : '0;
    assign ram_wdata  = reset ? wdata_c : '0;
    assign clear_busy = (state != ST_RUN);

    // Clear address counter, restarted on every entry into CLEAR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_cnt <= '0;
        end else if (state != ST_CLEAR && state_nxt == ST_CLEAR) begin
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // Posted write buffer: a new write may replace an entry draining now.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_full <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
        end else if (wr_acc) begin
            buf_full <= 1'b1;
            buf_addr <= cpu_addr;
            buf_data <= cpu_wdata;
        end else if (drain) begin
            buf_full <= 1'b0;
        end
    end

    // Starvation counter: counts CPU-side losses, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (state != ST_CLEAR && cpu_side) begin
            if (cpu_won) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // Read-return flags, one cycle behind the accepting grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vga_valid    <= 1'b0;
            vga_from_ram <= 1'b0;
            cpu_rvalid   <= 1'b0;
        end else begin
            vga_valid    <= vga_gnt_c;
            vga_from_ram <= (slot == SL_VGA);
            cpu_rvalid   <= (slot == SL_CRD);
        end
    end

    // VGA reads during CLEAR return zero without touching the RAM.
    assign vga_data  = vga_from_ram ? ram_rdata : '0;
    assign cpu_rdata = cpu_rvalid ? ram_rdata : '0;

endmodule
